// File: rtl/axis_symbol_mapper.sv
// axis_symbol_mapper
// Bit-to-constellation mapper for the TX path. Each packed input word is
// split MSB-first into BPSK, QPSK or 16-QAM symbols. Every symbol leaves as
// a signed {I, Q} pair on an AXI-Stream-style output. The frame-end marker
// of a word is attached to that word's last symbol.
module axis_symbol_mapper #(
   parameter int          IN_BYTES  = 1,
   parameter int          OUT_WIDTH = 12,
   parameter int unsigned AMPLITUDE = 12'h5a7
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [1:0]               i_mode,
   input  logic [8*IN_BYTES-1:0]    i_s_data,
   input  logic                     i_s_valid,
   input  logic                     i_s_last,
   output logic                     o_s_ready,
   output logic [2*OUT_WIDTH-1:0]   o_m_data,
   output logic                     o_m_valid,
   output logic                     o_m_last,
   input  logic                     i_m_ready
);

   localparam int W  = 8 * IN_BYTES;
   localparam int CW = $clog2(W + 1);

   localparam logic [1:0] MODE_BPSK  = 2'd0;
   localparam logic [1:0] MODE_QAM16 = 2'd2;

   // Outer level +/-A and inner level +/-a, where a = floor(A/3).
   localparam int unsigned            AMP_LOW   = AMPLITUDE / 32'd3;
   localparam logic [OUT_WIDTH-1:0]   LVL_A_POS = OUT_WIDTH'(AMPLITUDE);
   localparam logic [OUT_WIDTH-1:0]   LVL_A_NEG = OUT_WIDTH'(32'd0 - AMPLITUDE);
   localparam logic [OUT_WIDTH-1:0]   LVL_L_POS = OUT_WIDTH'(AMP_LOW);
   localparam logic [OUT_WIDTH-1:0]   LVL_L_NEG = OUT_WIDTH'(32'd0 - AMP_LOW);
   localparam logic [OUT_WIDTH-1:0]   LVL_ZERO  = {OUT_WIDTH{1'b0}};
   localparam logic [CW-1:0]          REM_ZERO  = {CW{1'b0}};
   localparam logic [CW-1:0]          REM_ONE   = CW'(1);

   // The mapping tables assume whole 16-QAM symbols per word, and the
   // amplitude must be a positive value in the signed output range.
   if ((W % 4) != 0) begin : g_bad_width
      $error("axis_symbol_mapper: word width %0d is not a multiple of 4", W);
   end
   if ((AMPLITUDE == 32'd0) || (AMPLITUDE >= (32'd1 << (OUT_WIDTH - 1)))) begin : g_bad_amp
      $error("axis_symbol_mapper: AMPLITUDE %0d does not fit in %0d bits", AMPLITUDE, OUT_WIDTH - 1);
   end

   // Symbols per word for a given mode. The reserved mode behaves as QPSK.
   function automatic logic [CW-1:0] f_spw(input logic [1:0] mode);
      logic [CW-1:0] v;
      case (mode)
         MODE_BPSK:  v = CW'(W);
         MODE_QAM16: v = CW'(W / 4);
         default:    v = CW'(W / 2);
      endcase
      return v;
   endfunction

   // Gray-coded 16-QAM axis level: sign bit selects polarity, mag bit inner level.
   function automatic logic [OUT_WIDTH-1:0] f_qam_level(input logic sign, input logic mag);
      logic [OUT_WIDTH-1:0] v;
      if (mag) begin
         v = sign ? LVL_L_NEG : LVL_L_POS;
      end else begin
         v = sign ? LVL_A_NEG : LVL_A_POS;
      end
      return v;
   endfunction

   logic [W-1:0]          r_sr;
   logic [CW-1:0]         r_rem;
   logic [1:0]            r_mode;
   logic                  r_last;

   logic                  w_out_valid;
   logic                  w_in_ready;
   logic                  w_in_hs;
   logic                  w_out_hs;
   logic [W-1:0]          w_sr_shift;
   logic [OUT_WIDTH-1:0]  w_i;
   logic [OUT_WIDTH-1:0]  w_q;

   assign w_out_valid = (r_rem != REM_ZERO);
   // Accepting at rem==1 while the last symbol drains keeps back-to-back words bubble-free.
   assign w_in_ready  = (r_rem == REM_ZERO) || ((r_rem == REM_ONE) && i_m_ready);
   assign w_in_hs     = i_s_valid && w_in_ready;
   assign w_out_hs    = w_out_valid && i_m_ready;

   // Shift amount follows the mode latched with the current word.
   always_comb begin
      w_sr_shift = r_sr;
      case (r_mode)
         MODE_BPSK:  w_sr_shift = {r_sr[W-2:0], 1'b0};
         MODE_QAM16: w_sr_shift = {r_sr[W-5:0], 4'b0000};
         default:    w_sr_shift = {r_sr[W-3:0], 2'b00};
      endcase
   end

   // Word load has priority over symbol advance; otherwise state is held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sr   <= {W{1'b0}};
         r_rem  <= REM_ZERO;
         r_mode <= MODE_BPSK;
         r_last <= 1'b0;
      end else if (w_in_hs) begin
         r_sr   <= i_s_data;
         r_rem  <= f_spw(i_mode);
         r_mode <= i_mode;
         r_last <= i_s_last;
      end else if (w_out_hs) begin
         r_sr   <= w_sr_shift;
         r_rem  <= r_rem - REM_ONE;
         r_mode <= r_mode;
         r_last <= r_last;
      end else begin
         r_sr   <= r_sr;
         r_rem  <= r_rem;
         r_mode <= r_mode;
         r_last <= r_last;
      end
   end

   // Map the top bits of the shift register to I/Q; zero whenever no symbol is pending.
   always_comb begin
      w_i = LVL_ZERO;
      w_q = LVL_ZERO;
      if (w_out_valid) begin
         case (r_mode)
            MODE_BPSK: begin
               w_i = r_sr[W-1] ? LVL_A_NEG : LVL_A_POS;
               w_q = LVL_ZERO;
            end
            MODE_QAM16: begin
               w_i = f_qam_level(r_sr[W-1], r_sr[W-2]);
               w_q = f_qam_level(r_sr[W-3], r_sr[W-4]);
            end
            default: begin
               w_i = r_sr[W-1] ? LVL_A_NEG : LVL_A_POS;
               w_q = r_sr[W-2] ? LVL_A_NEG : LVL_A_POS;
            end
         endcase
      end else begin
         w_i = LVL_ZERO;
         w_q = LVL_ZERO;
      end
   end

   assign o_m_data  = {w_i, w_q};
   assign o_m_valid = w_out_valid;
   assign o_m_last  = r_last && (r_rem == REM_ONE);
   assign o_s_ready = w_in_ready;

endmodule

// File: tb/tb_axis_symbol_mapper.sv
// tb_axis_symbol_mapper
// Scoreboard bench: each accepted input word pushes its expected symbols
// (from an arithmetic reference model) into a queue. Each output handshake
// pops one symbol and compares it.
module tb_axis_symbol_mapper;

   localparam int AMP_HI = 1447;  // 0x5a7
   localparam int AMP_LO = 482;   // floor(0x5a7 / 3) = 0x1e2

   logic        clk;
   logic        rst_n;
   logic [1:0]  d_mode;
   logic [7:0]  d_data;
   logic        d_valid;
   logic        d_last;
   logic        d_ordy;
   logic        o_s_ready;
   logic [23:0] o_m_data;
   logic        o_m_valid;
   logic        o_m_last;

   axis_symbol_mapper #(
      .IN_BYTES  (1),
      .OUT_WIDTH (12),
      .AMPLITUDE (12'h5a7)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_mode    (d_mode),
      .i_s_data  (d_data),
      .i_s_valid (d_valid),
      .i_s_last  (d_last),
      .o_s_ready (o_s_ready),
      .o_m_data  (o_m_data),
      .o_m_valid (o_m_valid),
      .o_m_last  (o_m_last),
      .i_m_ready (d_ordy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [24:0] sb[$];
   bit          accepted;
   bit          obs_valid;
   bit          obs_s_ready;
   bit          prev_valid;
   bit          prev_ordy;
   logic [23:0] prev_data;
   logic        prev_last;
   bit          bp_en;
   bit          rnd_en;
   int          bp_idx;
   logic [3:0]  bp_pat;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [11:0] lvl(input bit sign, input bit mag, input bit qam);
      int v;
      v = (qam && mag) ? AMP_LO : AMP_HI;
      if (sign) v = -v;
      return 12'(v);
   endfunction

   task automatic push_word(input logic [7:0] data, input logic [1:0] mode, input logic last);
      int bps;
      int hi;
      logic [11:0] iv;
      logic [11:0] qv;
      case (mode)
         2'd0:    bps = 1;
         2'd2:    bps = 4;
         default: bps = 2;
      endcase
      for (int k = 0; k < 8 / bps; k++) begin
         hi = 7 - bps * k;
         if (bps == 1) begin
            iv = lvl(data[hi], 1'b0, 1'b0);
            qv = 12'h000;
         end else if (bps == 2) begin
            iv = lvl(data[hi], 1'b0, 1'b0);
            qv = lvl(data[hi-1], 1'b0, 1'b0);
         end else begin
            iv = lvl(data[hi], data[hi-1], 1'b1);
            qv = lvl(data[hi-2], data[hi-3], 1'b1);
         end
         sb.push_back({(last && (k == 8 / bps - 1)), iv, qv});
      end
   endtask

   // One clock cycle: called at a negedge with inputs set; observes, scores, advances.
   task automatic tick();
      logic [24:0] e;
      if (bp_en) begin
         d_ordy = bp_pat[bp_idx];
         bp_idx = (bp_idx + 1) % 4;
      end else if (rnd_en) begin
         d_ordy = ($urandom_range(0, 3) != 0);
      end
      #1;
      obs_valid   = o_m_valid;
      obs_s_ready = o_s_ready;
      if (prev_valid && !prev_ordy)
         chk("stall_hold", 32'({o_m_valid, o_m_last, o_m_data}), 32'({1'b1, prev_last, prev_data}));
      if (!o_m_valid) begin
         chk("idle_zero", 32'({o_m_last, o_m_data}), 32'd0);
      end else if (d_ordy) begin
         if (sb.size() == 0) begin
            chk("spurious_symbol", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("symbol", 32'({o_m_last, o_m_data}), 32'(e));
         end
      end
      prev_valid = o_m_valid;
      prev_ordy  = d_ordy;
      prev_data  = o_m_data;
      prev_last  = o_m_last;
      accepted   = d_valid && o_s_ready;
      if (accepted) push_word(d_data, d_mode, d_last);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send_word(input logic [7:0] data, input logic [1:0] mode, input logic last, output int n);
      d_valid = 1'b1;
      d_data  = data;
      d_mode  = mode;
      d_last  = last;
      n       = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         n = i + 1;
         if (accepted) break;
      end
      if (!accepted) chk("accept_timeout", 32'd0, 32'd1);
      d_valid = 1'b0;
   endtask

   task automatic drain();
      d_valid = 1'b0;
      bp_en   = 1'b0;
      rnd_en  = 1'b0;
      d_ordy  = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if (sb.size() == 0) break;
         tick();
      end
      chk("drain_empty", 32'(sb.size()), 32'd0);
      tick();
      chk("idle_after_drain", 32'(obs_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_n = 1'b0;  d_mode = 2'd0; d_data = 8'h00; d_valid = 1'b0;
      d_last = 1'b0; d_ordy = 1'b1; bp_en = 1'b0; rnd_en = 1'b0;
      bp_idx = 0;    bp_pat = 4'b1001; prev_valid = 1'b0; prev_ordy = 1'b1;
      prev_data = 24'h0; prev_last = 1'b0; accepted = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_valid", 32'(o_m_valid), 32'd0);
      chk("rst_data",  32'(o_m_data),  32'd0);
      chk("rst_last",  32'(o_m_last),  32'd0);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", 32'(o_s_ready), 32'd1);
      @(negedge clk);

      // QPSK 0xB4: first symbol the next cycle, in_ready low 3 cycles then high.
      send_word(8'hB4, 2'd1, 1'b0, n);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("qpsk_valid", 32'(obs_valid), 32'd1);
         chk("qpsk_in_ready", 32'(obs_s_ready), (k == 3) ? 32'd1 : 32'd0);
      end
      drain();

      // BPSK 0xB4, then 16-QAM 0xB4 with frame end.
      send_word(8'hB4, 2'd0, 1'b0, n);
      drain();
      send_word(8'hB4, 2'd2, 1'b1, n);
      drain();

      // Backpressure with ready pattern 1,0,0,1.
      bp_en = 1'b1; bp_idx = 0;
      send_word(8'hB4, 2'd1, 1'b1, n);
      for (int k = 0; k < 12; k++) tick();
      drain();

      // Back-to-back words: second accepted on the old word's last symbol, no gap.
      send_word(8'hB4, 2'd1, 1'b0, n);
      send_word(8'h1E, 2'd1, 1'b1, n);
      chk("b2b_accept_cycles", 32'(n), 32'd4);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("b2b_no_bubble", 32'(obs_valid), 32'd1);
      end
      drain();

      // Mode switched to BPSK mid-word: rest of the word stays QPSK, next word is BPSK.
      send_word(8'hB4, 2'd1, 1'b0, n);
      tick();
      d_mode = 2'd0;
      send_word(8'h1E, 2'd0, 1'b1, n);
      drain();

      // Reserved mode behaves as QPSK.
      send_word(8'h6C, 2'd3, 1'b1, n);
      drain();

      // Asynchronous reset mid-word.
      send_word(8'hB4, 2'd1, 1'b1, n);
      tick();
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(o_m_valid), 32'd0);
      chk("async_rst_data",  32'(o_m_data),  32'd0);
      chk("async_rst_last",  32'(o_m_last),  32'd0);
      sb.delete();
      prev_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      send_word(8'hB4, 2'd2, 1'b1, n);
      drain();

      // Random words, modes and downstream stalls.
      rnd_en = 1'b1;
      for (int w = 0; w < 24; w++) begin
         send_word(8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), n);
         if ($urandom_range(0, 3) == 0) tick();
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
